// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV core: drives PC, IF/ID, ID/EX and EX/MEM
// enables/clears for load-use, redirects, data-memory wait and multi-cycle MUL/DIV ops.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MDU_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_wait,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clear,
  output logic             idex_en,
  output logic             idex_clear,
  output logic             exmem_en,
  output logic             exmem_clear,
  output logic             mdu_busy,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state
);

  localparam int WD_W = $clog2(MDU_MAX + 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } state_t;

  state_t            r_state;
  logic [WD_W-1:0]   r_wd;
  logic              r_done_pend;
  logic              r_mdu_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_lu;
  logic w_done;
  logic w_wd_exp;
  logic w_exit;
  logic w_redirect_acc;
  logic w_mdu_enter;

  assign w_lu = ex_memread & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  assign w_done   = mdu_done | r_done_pend;
  // wd saturates at MDU_MAX, so a timeout held off by mem_wait stays asserted
  assign w_wd_exp = (r_wd >= WD_W'(MDU_MAX)) & ~w_done;
  assign w_exit   = (r_state == ST_MDU) & (w_done | w_wd_exp) & ~mem_wait;

  assign w_redirect_acc = ~rst & (r_state == ST_RUN) & ~mem_wait & ex_redirect;
  assign w_mdu_enter    = ~rst & (r_state == ST_RUN) & ~mem_wait & ~ex_redirect & ex_mdu_start;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_clear  = 1'b0;
    idex_en     = 1'b1;
    idex_clear  = 1'b0;
    exmem_en    = 1'b1;
    exmem_clear = 1'b0;
    mdu_busy    = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_clear  = 1'b1;
      idex_en     = 1'b0;
      idex_clear  = 1'b1;
      exmem_en    = 1'b0;
      exmem_clear = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
          end else if (ex_redirect) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
          end else if (ex_mdu_start) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_clear = 1'b1;
          end else if (w_lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_clear = 1'b1;
          end
        end
        ST_MDU: begin
          mdu_busy = 1'b1;
          // Exit cycle: the MDU op leaves EX normally; only a load-use can still hold ID
          if (w_exit) begin
            if (w_lu) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_clear = 1'b1;
            end
          end else begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            if (mem_wait) begin
              exmem_en = 1'b0;
            end else begin
              exmem_clear = 1'b1;
            end
          end
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wd        <= '0;
      r_done_pend <= 1'b0;
      r_mdu_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mdu_enter) begin
            r_state     <= ST_MDU;
            r_wd        <= WD_W'(1);
            r_done_pend <= 1'b0;
          end
        end
        ST_MDU: begin
          if (mdu_done) begin
            r_done_pend <= 1'b1;
          end
          if (r_wd < WD_W'(MDU_MAX)) begin
            r_wd <= r_wd + WD_W'(1);
          end
          if (w_wd_exp) begin
            r_mdu_err <= 1'b1;
          end
          if (w_exit) begin
            r_state     <= ST_RUN;
            r_done_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase

      if (cnt_clr) begin
        r_stall_cnt <= '0;
      end else if (~pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      if (cnt_clr) begin
        r_flush_cnt <= '0;
      end else if (w_redirect_acc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mdu_err   = r_mdu_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle expected control vectors go through a scoreboard queue;
// counters, mdu_err and state are checked inline by each scenario task.
module tb_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int MDU_MAX = 6;

  // Control vector: {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, exmem_clear, mdu_busy}
  localparam logic [7:0] V_NORM     = 8'b1101_0100;
  localparam logic [7:0] V_RST      = 8'b0010_1010;
  localparam logic [7:0] V_LU       = 8'b0001_1100;
  localparam logic [7:0] V_MW       = 8'b0000_0000;
  localparam logic [7:0] V_REDIR    = 8'b1111_1100;
  localparam logic [7:0] V_MSTART   = 8'b0000_0110;
  localparam logic [7:0] V_MDU      = 8'b0000_0111;
  localparam logic [7:0] V_MDU_MW   = 8'b0000_0001;
  localparam logic [7:0] V_MEXIT    = 8'b1101_0101;
  localparam logic [7:0] V_MEXIT_LU = 8'b0001_1101;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
  logic             ex_mdu_start, mdu_done, mem_wait, cnt_clr;
  logic             pc_en, ifid_en, ifid_clear, idex_en, idex_clear;
  logic             exmem_en, exmem_clear, mdu_busy, mdu_err, dbg_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         checks   = 0;
  int         failures = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MDU_MAX(MDU_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clear(ifid_clear), .idex_en(idex_en),
    .idex_clear(idex_clear), .exmem_en(exmem_en), .exmem_clear(exmem_clear),
    .mdu_busy(mdu_busy), .mdu_err(mdu_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and timeout
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Scoreboard: compare the control vector mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] exp_v;
      logic [7:0] obs_v;
      string      tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      obs_v = {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, exmem_clear, mdu_busy};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL %s ctrl got=%b exp=%b", tag, obs_v, exp_v);
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    ex_mdu_start = 1'b0; mdu_done = 1'b0; mem_wait = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic cycle(input logic [7:0] exp_v, input string tag);
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    idle_inputs();
    cnt_clr = 1'b1;
    cycle(V_NORM, "cnt_clr");
    cnt_clr = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cycle(V_RST, "reset_ctrl");
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 3'd0) begin failures++; $display("FAIL reset_flush got=%0d exp=0", flush_cnt); end
    checks++; if (mdu_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mdu_err); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    rst = 1'b0;
    cycle(V_NORM, "idle");
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL idle_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cycle(V_LU, "lu_rs1");
    checks++; if (stall_cnt !== 3'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall_cnt); end
    ex_rd = 5'd0; id_rs1 = 5'd0;
    cycle(V_NORM, "lu_x0");
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1;
    cycle(V_LU, "lu_rs2");
    id_use_rs2 = 1'b0;
    cycle(V_NORM, "lu_unused");
    ex_memread = 1'b0; id_use_rs1 = 1'b1;
    cycle(V_NORM, "lu_not_load");
    checks++; if (stall_cnt !== 3'd2) begin failures++; $display("FAIL lu_stall2 got=%0d exp=2", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_redirect();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
    cycle(V_REDIR, "redir_lu");
    checks++; if (flush_cnt !== 3'd1) begin failures++; $display("FAIL redir_flush got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 3'd2) begin failures++; $display("FAIL redir_stall got=%0d exp=2", stall_cnt); end
    mem_wait = 1'b1;
    cycle(V_MW, "redir_memwait");
    checks++; if (flush_cnt !== 3'd1) begin failures++; $display("FAIL memwait_flush got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL memwait_stall got=%0d exp=3", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_mdu();
    clear_counters();
    ex_mdu_start = 1'b1; mem_wait = 1'b1;
    cycle(V_MW, "mdu_defer");
    mem_wait = 1'b0;
    cycle(V_MSTART, "mdu_start");
    for (int i = 0; i < 4; i++) cycle(V_MDU, "mdu_busy");
    mdu_done = 1'b1;
    cycle(V_MEXIT, "mdu_exit");
    idle_inputs();
    cycle(V_NORM, "mdu_after");
    checks++; if (stall_cnt !== 3'd6) begin failures++; $display("FAIL mdu_stall got=%0d exp=6", stall_cnt); end
    checks++; if (mdu_err !== 1'b0) begin failures++; $display("FAIL mdu_err got=%b exp=0", mdu_err); end
  endtask

  task automatic test_mdu_mem_wait();
    clear_counters();
    ex_mdu_start = 1'b1;
    cycle(V_MSTART, "mdumw_start");
    cycle(V_MDU, "mdumw_busy");
    cycle(V_MDU, "mdumw_busy");
    mdu_done = 1'b1; mem_wait = 1'b1;
    cycle(V_MDU_MW, "mdumw_done_held");
    mdu_done = 1'b0;
    cycle(V_MDU_MW, "mdumw_pend");
    cycle(V_MDU_MW, "mdumw_pend");
    mem_wait = 1'b0;
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    cycle(V_MEXIT_LU, "mdumw_exit_lu");
    idle_inputs();
    cycle(V_NORM, "mdumw_after");
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL mdumw_stall got=%0d exp=7", stall_cnt); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL mdumw_state got=%b exp=0", dbg_state); end
  endtask

  task automatic test_watchdog();
    clear_counters();
    ex_mdu_start = 1'b1;
    cycle(V_MSTART, "wd_start");
    for (int i = 0; i < MDU_MAX - 1; i++) begin
      cycle(V_MDU, "wd_busy");
      checks++; if (mdu_err !== 1'b0) begin failures++; $display("FAIL wd_early got=%b exp=0", mdu_err); end
    end
    cycle(V_MEXIT, "wd_exit");
    checks++; if (mdu_err !== 1'b1) begin failures++; $display("FAIL wd_err got=%b exp=1", mdu_err); end
    idle_inputs();
    mdu_done = 1'b1;
    cycle(V_NORM, "wd_done_in_run");
    mdu_done = 1'b0;
    cycle(V_NORM, "wd_run");
    ex_mdu_start = 1'b1;
    cycle(V_MSTART, "wd_op2_start");
    mdu_done = 1'b1;
    cycle(V_MEXIT, "wd_op2_exit");
    idle_inputs();
    cycle(V_NORM, "wd_op2_after");
    checks++; if (mdu_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", mdu_err); end
  endtask

  task automatic test_counters();
    int n;
    clear_counters();
    n = $urandom_range(9, 12);
    mem_wait = 1'b1;
    for (int i = 0; i < n; i++) cycle(V_MW, "sat_stall");
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL stall_sat got=%0d exp=7", stall_cnt); end
    checks++; if (flush_cnt !== 3'd0) begin failures++; $display("FAIL flush_idle got=%0d exp=0", flush_cnt); end
    cnt_clr = 1'b1;
    cycle(V_MW, "clr_vs_stall");
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL clr_priority got=%0d exp=0", stall_cnt); end
    idle_inputs();
    ex_redirect = 1'b1;
    for (int i = 0; i < n; i++) cycle(V_REDIR, "sat_flush");
    checks++; if (flush_cnt !== 3'd7) begin failures++; $display("FAIL flush_sat got=%0d exp=7", flush_cnt); end
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL redir_nostall got=%0d exp=0", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_rst_mid_mdu();
    ex_mdu_start = 1'b1;
    cycle(V_MSTART, "rstm_start");
    cycle(V_MDU, "rstm_busy");
    idle_inputs();
    rst = 1'b1;
    cycle(V_RST, "rstm_reset");
    rst = 1'b0;
    cycle(V_NORM, "rstm_run");
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL rstm_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 3'd0) begin failures++; $display("FAIL rstm_flush got=%0d exp=0", flush_cnt); end
    checks++; if (mdu_err !== 1'b0) begin failures++; $display("FAIL rstm_err got=%b exp=0", mdu_err); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL rstm_state got=%b exp=0", dbg_state); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_mdu();
    test_mdu_mem_wait();
    test_watchdog();
    test_counters();
    test_rst_mid_mdu();
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
